// File: rtl/phy_reconfig_seq.sv
// PHY reconfiguration sequencer.
// Takes a mode-change request, waits for the datapath to drain at a symbol
// boundary, holds the datapath in reset, loads the new mode, lets it settle
// and then acknowledges. After rst the same sequence runs once with mode 0
// and no acknowledge.
module phy_reconfig_seq #(
  parameter int RST_CYCLES    = 61,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_data,
  input  logic       reconfig_req,
  input  logic [1:0] reconfig_mode,
  input  logic       dp_busy,
  output logic       dp_rst,
  output logic [1:0] mode_cfg,
  output logic       mode_load,
  output logic       reconfig_ack,
  output logic       err_invalid,
  output logic       ready
);

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRAIN  = 3'd1;
  localparam logic [2:0] ST_RESET  = 3'd2;
  localparam logic [2:0] ST_LOAD   = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Terminal counts: the counter runs 0..LAST, so it spends LAST+1 cycles
  // in the state and never reaches a value that could wrap.
  localparam logic [7:0] RST_LAST    = 8'(RST_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  localparam logic [1:0] MODE_INVALID = 2'd3;

  // Registered state and outputs
  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_pending;
  logic [1:0] r_mode_cfg;
  logic       r_dp_rst;
  logic       r_mode_load;
  logic       r_ack;
  logic       r_err;
  logic       r_ready;
  logic       r_post_rst;
  logic       r_clk_data_d;

  // Next-state values
  logic [2:0] w_state_nx;
  logic [7:0] w_cnt_nx;
  logic [1:0] w_pending_nx;
  logic [1:0] w_mode_cfg_nx;
  logic       w_dp_rst_nx;
  logic       w_mode_load_nx;
  logic       w_ack_nx;
  logic       w_err_nx;
  logic       w_ready_nx;
  logic       w_post_rst_nx;

  // Symbol boundary: clk_data was low last cycle and is high now
  logic       w_edge;

  assign w_edge = clk_data & ~r_clk_data_d;

  // Next-state and next-output logic; every output is computed for the
  // state being entered so the registered outputs line up with r_state.
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_pending_nx   = r_pending;
    w_mode_cfg_nx  = r_mode_cfg;
    w_dp_rst_nx    = r_dp_rst;
    w_mode_load_nx = 1'b0;
    w_ack_nx       = 1'b0;
    w_err_nx       = 1'b0;
    w_ready_nx     = r_ready;
    w_post_rst_nx  = r_post_rst;

    case (r_state)
      ST_IDLE: begin
        w_ready_nx  = 1'b1;
        w_dp_rst_nx = 1'b0;
        if (reconfig_req) begin
          if (reconfig_mode == MODE_INVALID) begin
            // Rejected: report and acknowledge, nothing else changes
            w_err_nx = 1'b1;
            w_ack_nx = 1'b1;
          end else if (reconfig_mode == r_mode_cfg) begin
            // Already in the requested mode: no reset needed
            w_ack_nx = 1'b1;
          end else begin
            w_pending_nx  = reconfig_mode;
            w_state_nx    = ST_DRAIN;
            w_ready_nx    = 1'b0;
            w_post_rst_nx = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        // Only cut in at a symbol boundary with nothing in flight
        if (w_edge && !dp_busy) begin
          w_state_nx  = ST_RESET;
          w_cnt_nx    = 8'd0;
          w_dp_rst_nx = 1'b1;
        end
      end

      ST_RESET: begin
        w_dp_rst_nx = 1'b1;
        if (r_cnt >= RST_LAST) begin
          w_state_nx = ST_LOAD;
          w_cnt_nx   = 8'd0;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end

      ST_LOAD: begin
        // dp_rst stays high through this cycle and drops with the new mode
        w_mode_cfg_nx  = r_pending;
        w_mode_load_nx = 1'b1;
        w_dp_rst_nx    = 1'b0;
        w_cnt_nx       = 8'd0;
        w_state_nx     = ST_SETTLE;
      end

      ST_SETTLE: begin
        w_dp_rst_nx = 1'b0;
        if (r_cnt >= SETTLE_LAST) begin
          w_state_nx = ST_DONE;
          w_cnt_nx   = 8'd0;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end

      ST_DONE: begin
        // The power-on sequence completes silently
        w_ack_nx      = ~r_post_rst;
        w_post_rst_nx = 1'b0;
        w_ready_nx    = 1'b1;
        w_state_nx    = ST_IDLE;
      end

      default: begin
        // Unreachable encodings recover through a full reset sequence
        w_state_nx    = ST_RESET;
        w_cnt_nx      = 8'd0;
        w_pending_nx  = 2'd0;
        w_dp_rst_nx   = 1'b1;
        w_ready_nx    = 1'b0;
        w_post_rst_nx = 1'b1;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RESET;
      r_cnt        <= 8'd0;
      r_pending    <= 2'd0;
      r_mode_cfg   <= 2'd0;
      r_dp_rst     <= 1'b1;
      r_mode_load  <= 1'b0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_ready      <= 1'b0;
      r_post_rst   <= 1'b1;
      r_clk_data_d <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_pending    <= w_pending_nx;
      r_mode_cfg   <= w_mode_cfg_nx;
      r_dp_rst     <= w_dp_rst_nx;
      r_mode_load  <= w_mode_load_nx;
      r_ack        <= w_ack_nx;
      r_err        <= w_err_nx;
      r_ready      <= w_ready_nx;
      r_post_rst   <= w_post_rst_nx;
      r_clk_data_d <= clk_data;
    end
  end

  assign dp_rst       = r_dp_rst;
  assign mode_cfg     = r_mode_cfg;
  assign mode_load    = r_mode_load;
  assign reconfig_ack = r_ack;
  assign err_invalid  = r_err;
  assign ready        = r_ready;

endmodule

// File: tb/tb_phy_reconfig_seq.sv
// Scoreboard bench for phy_reconfig_seq: expected ack/mode_load events are
// queued when stimulus is driven and matched as the DUT emits them.
module tb_phy_reconfig_seq;

  localparam int RST_C = 61;
  localparam int SET_C = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_data = 1'b0;
  logic       reconfig_req = 1'b0;
  logic [1:0] reconfig_mode = 2'd0;
  logic       dp_busy = 1'b0;
  logic       dp_rst;
  logic [1:0] mode_cfg;
  logic       mode_load;
  logic       reconfig_ack;
  logic       err_invalid;
  logic       ready;

  phy_reconfig_seq #(.RST_CYCLES(RST_C), .SETTLE_CYCLES(SET_C)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_data     (clk_data),
    .reconfig_req (reconfig_req),
    .reconfig_mode(reconfig_mode),
    .dp_busy      (dp_busy),
    .dp_rst       (dp_rst),
    .mode_cfg     (mode_cfg),
    .mode_load    (mode_load),
    .reconfig_ack (reconfig_ack),
    .err_invalid  (err_invalid),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic       err;
    logic [1:0] mode;
  } exp_t;

  exp_t q_ack[$];
  exp_t q_load[$];

  int n_chk  = 0;
  int n_fail = 0;

  // dp_rst run tracking (cycles high while rst is low)
  int run = 0;
  int last_len = 0;
  int last_fall = 0;
  int last_rise = 0;
  int runs = 0;
  logic prev_dp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [1:0] m, output int t);
    step(1);
    reconfig_req  = 1'b1;
    reconfig_mode = m;
    t = cyc;
    step(1);
    reconfig_req = 1'b0;
  endtask

  task automatic data_edge(output int e);
    step(1);
    clk_data = 1'b1;
    e = cyc;
    step(2);
    clk_data = 1'b0;
    step(2);
  endtask

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    while (!ready && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!ready) chk("ready_timeout", ready, 1);
  endtask

  task automatic push_seq(input int e, input logic [1:0] m);
    exp_t x;
    x.at = e + RST_C + 2; x.err = 1'b0; x.mode = m;
    q_load.push_back(x);
    x.at = e + RST_C + SET_C + 3;
    q_ack.push_back(x);
  endtask

  // Output monitor: scoreboard matching and dp_rst run measurement
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (reconfig_ack) begin
        if (q_ack.size() == 0) chk("unexpected_ack", q_ack.size(), 1);
        else begin
          x = q_ack.pop_front();
          chk("ack_cycle", cyc, x.at);
          chk("ack_err", err_invalid, x.err);
          chk("ack_mode", mode_cfg, x.mode);
        end
      end else if (err_invalid) begin
        chk("err_without_ack", reconfig_ack, 1);
      end
      if (mode_load) begin
        if (q_load.size() == 0) chk("unexpected_load", q_load.size(), 1);
        else begin
          x = q_load.pop_front();
          chk("load_cycle", cyc, x.at);
          chk("load_mode", mode_cfg, x.mode);
        end
      end
      if (dp_rst && !prev_dp) last_rise = cyc;
      if (rst) run = 0;
      else if (dp_rst) run++;
      else if (run > 0) begin
        last_len  = run;
        last_fall = cyc;
        runs++;
        run = 0;
      end
      prev_dp = dp_rst;
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, e, rel, runs0;
    exp_t x;

    // Power-on
    step(3);
    chk("por_dp_rst", dp_rst, 1);
    chk("por_ready", ready, 0);
    chk("por_mode", mode_cfg, 0);
    chk("por_ack", reconfig_ack, 0);
    chk("por_load", mode_load, 0);
    step(2);
    rst = 1'b0;
    rel = cyc;
    x.at = rel + RST_C + 1; x.err = 1'b0; x.mode = 2'd0;
    q_load.push_back(x);
    wait_ready(200);
    chk("por_ready_cycle", cyc, rel + RST_C + SET_C + 2);
    chk("por_rst_len", last_len, RST_C + 1);
    chk("por_rst_fall", last_fall, rel + RST_C + 1);
    chk("por_runs", runs, 1);

    // Normal change to mode 2, edge 7 cycles after the request
    pulse_req(2'd2, t);
    chk("drain_ready", ready, 0);
    chk("drain_dp_rst", dp_rst, 0);
    step(5);
    data_edge(e);
    chk("norm_edge_gap", e - t, 7);
    push_seq(e, 2'd2);
    wait_ready(300);
    chk("norm_rise", last_rise, e + 1);
    chk("norm_rst_len", last_len, RST_C + 1);
    chk("norm_mode", mode_cfg, 2);
    chk("norm_runs", runs, 2);

    // Busy hold-off across three edges
    dp_busy = 1'b1;
    pulse_req(2'd1, t);
    repeat (3) data_edge(e);
    chk("busy_dp_rst", dp_rst, 0);
    chk("busy_runs", runs, 2);
    chk("busy_ready", ready, 0);
    dp_busy = 1'b0;
    data_edge(e);
    push_seq(e, 2'd1);
    wait_ready(300);
    chk("busy_rise", last_rise, e + 1);
    chk("busy_mode", mode_cfg, 1);

    // Trivial and invalid requests
    runs0 = runs;
    pulse_req(2'd1, t);
    x.at = t + 1; x.err = 1'b0; x.mode = 2'd1;
    q_ack.push_back(x);
    step(3);
    chk("triv_dp_rst", dp_rst, 0);
    chk("triv_runs", runs, runs0);
    pulse_req(2'd3, t);
    x.at = t + 1; x.err = 1'b1; x.mode = 2'd1;
    q_ack.push_back(x);
    step(2);
    chk("inv_mode", mode_cfg, 1);
    chk("inv_ready", ready, 1);

    // Request dropped during SETTLE
    pulse_req(2'd2, t);
    step(2);
    data_edge(e);
    push_seq(e, 2'd2);
    step(RST_C + 3);
    chk("drop_in_settle", dp_rst, 0);
    pulse_req(2'd0, t);
    wait_ready(100);
    step(10);
    chk("drop_mode", mode_cfg, 2);
    chk("drop_ack_q", q_ack.size(), 0);

    // Reset at RESET count 30
    pulse_req(2'd1, t);
    step(1);
    data_edge(e);
    step(e + 31 - cyc);
    chk("mid_in_reset", dp_rst, 1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_mode", mode_cfg, 0);
    chk("mid_rst_ready", ready, 0);
    step(1);
    rst = 1'b0;
    rel = cyc;
    q_load.delete();
    q_ack.delete();
    x.at = rel + RST_C + 1; x.err = 1'b0; x.mode = 2'd0;
    q_load.push_back(x);
    wait_ready(200);
    chk("mid_rst_len", last_len, RST_C + 1);
    chk("mid_rst_fall", last_fall, rel + RST_C + 1);
    chk("mid_mode", mode_cfg, 0);
    step(20);
    chk("end_ack_q", q_ack.size(), 0);
    chk("end_load_q", q_load.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
